// File: rtl/smoker_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | smoker_pkg : mode encodings and clock defaults shared by smoker blocks |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package smoker_pkg;

    localparam int DEFAULT_CLK_FREQ = 100_000_000;

    localparam logic [2:0] MODE_STANDBY   = 3'b000;
    localparam logic [2:0] MODE_1         = 3'b001;
    localparam logic [2:0] MODE_2         = 3'b010;
    localparam logic [2:0] MODE_3         = 3'b011;
    localparam logic [2:0] MODE_CLEAN     = 3'b100;
    localparam logic [2:0] MODE_SHOW_ANN  = 3'b101;
    localparam logic [2:0] MODE_SHOW_GEST = 3'b110;
    localparam logic [2:0] MODE_SHOW_CUM  = 3'b111;

endpackage
`default_nettype wire

// File: rtl/sec_tick_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sec_tick_gen : one-cycle pulse every CLK_FREQ cycles while running    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module sec_tick_gen
    import smoker_pkg::*;
#(
    parameter int CLK_FREQ = DEFAULT_CLK_FREQ
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int            CW     = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(CLK_FREQ - 1);

    logic [CW-1:0] r_cnt;

    assign tick = run && (r_cnt == C_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hurricane_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | hurricane_ctrl : one-shot-per-power-on mode 3 supervisor and countdown |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module hurricane_ctrl
    import smoker_pkg::*;
#(
    parameter int CLK_FREQ      = DEFAULT_CLK_FREQ,
    parameter int HURRICANE_SEC = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       machine_state,
    input  logic [2:0] mode_state,
    input  logic       menu_btn,
    output logic       hurricane_mode_enabled,
    output logic       return_state,
    output logic [7:0] remaining_sec,
    output logic       countdown_active
);

    typedef enum logic [2:0] {
        ST_ARMED    = 3'd0,
        ST_RUN      = 3'd1,
        ST_RUN_MENU = 3'd2,
        ST_EXIT     = 3'd3,
        ST_USED     = 3'd4
    } hstate_t;

    localparam logic [7:0] C_LOAD = 8'(HURRICANE_SEC);

    hstate_t    r_state;
    logic       r_menu_prev;
    logic       r_enabled;
    logic       r_return;
    logic [7:0] r_sec;
    logic       r_active;

    logic w_in_mode3;
    logic w_running;
    logic w_menu_edge;
    logic w_tick;
    logic w_expire;
    logic w_clear;

    assign w_in_mode3  = (mode_state == MODE_3);
    assign w_running   = (r_state == ST_RUN) || (r_state == ST_RUN_MENU);
    assign w_menu_edge = menu_btn && !r_menu_prev;
    assign w_expire    = w_tick && (r_sec <= 8'd1);
    // Counter restarts on every load/reload and stays parked at zero when idle.
    assign w_clear     = !w_running || !machine_state || !w_in_mode3 || w_expire ||
                         ((r_state == ST_RUN) && w_menu_edge);

    sec_tick_gen #(
        .CLK_FREQ (CLK_FREQ)
    ) u_sec_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (w_clear),
        .run   (w_running),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_ARMED;
            r_menu_prev <= 1'b0;
            r_enabled   <= 1'b1;
            r_return    <= 1'b0;
            r_sec       <= 8'd0;
            r_active    <= 1'b0;
        end else begin
            r_menu_prev <= menu_btn;
            if (!machine_state) begin
                r_state   <= ST_ARMED;
                r_enabled <= 1'b1;
                r_return  <= 1'b0;
                r_sec     <= 8'd0;
                r_active  <= 1'b0;
            end else begin
                case (r_state)
                    ST_ARMED: begin
                        if (w_in_mode3) begin
                            r_state   <= ST_RUN;
                            r_enabled <= 1'b1;
                            r_sec     <= C_LOAD;
                            r_active  <= 1'b1;
                        end
                    end
                    ST_RUN, ST_RUN_MENU: begin
                        if (!w_in_mode3) begin
                            r_state   <= ST_USED;
                            r_enabled <= 1'b0;
                            r_return  <= 1'b0;
                            r_sec     <= 8'd0;
                            r_active  <= 1'b0;
                        end else if (w_expire) begin
                            // Expiry beats a coincident menu edge.
                            r_state   <= ST_EXIT;
                            r_enabled <= 1'b0;
                            r_return  <= (r_state == ST_RUN);
                            r_sec     <= 8'd0;
                            r_active  <= 1'b0;
                        end else if ((r_state == ST_RUN) && w_menu_edge) begin
                            r_state <= ST_RUN_MENU;
                            r_sec   <= C_LOAD;
                        end else if (w_tick) begin
                            r_sec <= (r_sec != 8'd0) ? r_sec - 8'd1 : 8'd0;
                        end
                    end
                    ST_EXIT: begin
                        if (!w_in_mode3) begin
                            r_state  <= ST_USED;
                            r_return <= 1'b0;
                        end
                    end
                    ST_USED: begin
                        r_enabled <= 1'b0;
                        r_return  <= 1'b0;
                        r_sec     <= 8'd0;
                        r_active  <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_ARMED;
                    end
                endcase
            end
        end
    end

    assign hurricane_mode_enabled = r_enabled;
    assign return_state           = r_return;
    assign remaining_sec          = r_sec;
    assign countdown_active       = r_active;

endmodule
`default_nettype wire

// File: tb/tb_hurricane_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_hurricane_ctrl : directed scoreboard bench, CLK_FREQ=10, 3 s runs   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_hurricane_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       machine_state;
    logic [2:0] mode_state;
    logic       menu_btn;
    logic       hurricane_mode_enabled;
    logic       return_state;
    logic [7:0] remaining_sec;
    logic       countdown_active;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       tag;
        logic [10:0] val;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    hurricane_ctrl #(
        .CLK_FREQ      (10),
        .HURRICANE_SEC (3)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .machine_state          (machine_state),
        .mode_state             (mode_state),
        .menu_btn               (menu_btn),
        .hurricane_mode_enabled (hurricane_mode_enabled),
        .return_state           (return_state),
        .remaining_sec          (remaining_sec),
        .countdown_active       (countdown_active)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string tag, input logic en, input logic rs,
                            input logic [7:0] sec, input logic act);
        exp_t e;
        e.tag = tag;
        e.val = {en, rs, sec, act};
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t        e;
        logic [10:0] obs;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $error("FAIL scoreboard_empty: observed no entry, expected one");
        end else begin
            e   = exp_q.pop_front();
            obs = {hurricane_mode_enabled, return_state, remaining_sec, countdown_active};
            assert (obs === e.val) else begin
                n_bad++;
                $error("FAIL %s: observed en=%b ret=%b sec=%0d act=%b, expected en=%b ret=%b sec=%0d act=%b",
                       e.tag, obs[10], obs[9], obs[8:1], obs[0],
                       e.val[10], e.val[9], e.val[8:1], e.val[0]);
            end
        end
    endtask

    task automatic chk(input int n, input string tag, input logic en, input logic rs,
                       input logic [7:0] sec, input logic act);
        push_exp(tag, en, rs, sec, act);
        cyc(n);
        pop_cmp();
    endtask

    task automatic rearm(input string tag);
        mode_state    = 3'd0;
        machine_state = 1'b0;
        chk(1, tag, 1'b1, 1'b0, 8'd0, 1'b0);
        machine_state = 1'b1;
        cyc(1);
    endtask

    initial begin
        rst           = 1'b0;
        machine_state = 1'b0;
        mode_state    = 3'd0;
        menu_btn      = 1'b0;
        chk(2, "reset", 1'b1, 1'b0, 8'd0, 1'b0);
        rst           = 1'b1;
        machine_state = 1'b1;
        chk(2, "armed_idle", 1'b1, 1'b0, 8'd0, 1'b0);

        // 1: plain run, expiry to mode 2, then locked out
        mode_state = 3'd3;
        chk(1,  "t1_load",      1'b1, 1'b0, 8'd3, 1'b1);
        chk(9,  "t1_pre_tick",  1'b1, 1'b0, 8'd3, 1'b1);
        chk(1,  "t1_tick1",     1'b1, 1'b0, 8'd2, 1'b1);
        chk(10, "t1_tick2",     1'b1, 1'b0, 8'd1, 1'b1);
        chk(9,  "t1_last_sec",  1'b1, 1'b0, 8'd1, 1'b1);
        chk(1,  "t1_expire",    1'b0, 1'b1, 8'd0, 1'b0);
        chk(3,  "t1_exit_hold", 1'b0, 1'b1, 8'd0, 1'b0);
        mode_state = 3'd2;
        chk(1,  "t1_used",      1'b0, 1'b0, 8'd0, 1'b0);
        mode_state = 3'd3;
        chk(3,  "t1_no_reentry", 1'b0, 1'b0, 8'd0, 1'b0);

        // 2: menu press reloads, later presses ignored, exit to standby
        rearm("t2_power_off");
        mode_state = 3'd3;
        chk(1,  "t2_load",        1'b1, 1'b0, 8'd3, 1'b1);
        chk(14, "t2_pre_menu",    1'b1, 1'b0, 8'd2, 1'b1);
        menu_btn = 1'b1;
        chk(1,  "t2_reload",      1'b1, 1'b0, 8'd3, 1'b1);
        menu_btn = 1'b0;
        chk(5,  "t2_after_menu",  1'b1, 1'b0, 8'd3, 1'b1);
        menu_btn = 1'b1;
        chk(1,  "t2_second_edge", 1'b1, 1'b0, 8'd3, 1'b1);
        menu_btn = 1'b0;
        chk(23, "t2_last_sec",    1'b1, 1'b0, 8'd1, 1'b1);
        chk(1,  "t2_expire",      1'b0, 1'b0, 8'd0, 1'b0);
        mode_state = 3'd0;
        chk(1,  "t2_used",        1'b0, 1'b0, 8'd0, 1'b0);

        // 3: menu edge coincident with final expiry
        rearm("t3_power_off");
        mode_state = 3'd3;
        chk(1,  "t3_load",      1'b1, 1'b0, 8'd3, 1'b1);
        chk(29, "t3_last_sec",  1'b1, 1'b0, 8'd1, 1'b1);
        menu_btn = 1'b1;
        chk(1,  "t3_race",      1'b0, 1'b1, 8'd0, 1'b0);
        menu_btn = 1'b0;
        chk(2,  "t3_race_hold", 1'b0, 1'b1, 8'd0, 1'b0);
        mode_state = 3'd0;
        chk(1,  "t3_used",      1'b0, 1'b0, 8'd0, 1'b0);

        // 4: power dropped mid-run, then full re-entry
        rearm("t4_power_off");
        mode_state = 3'd3;
        chk(1,  "t4_load",       1'b1, 1'b0, 8'd3, 1'b1);
        chk(12, "t4_mid_run",    1'b1, 1'b0, 8'd2, 1'b1);
        machine_state = 1'b0;
        chk(1,  "t4_power_drop", 1'b1, 1'b0, 8'd0, 1'b0);
        machine_state = 1'b1;
        chk(1,  "t4_reload",     1'b1, 1'b0, 8'd3, 1'b1);
        chk(29, "t4_last_sec",   1'b1, 1'b0, 8'd1, 1'b1);
        chk(1,  "t4_expire",     1'b0, 1'b1, 8'd0, 1'b0);

        // 5: asynchronous reset in RUN_MENU
        rearm("t5_power_off");
        mode_state = 3'd3;
        chk(1, "t5_load", 1'b1, 1'b0, 8'd3, 1'b1);
        menu_btn = 1'b1;
        chk(1, "t5_run_menu", 1'b1, 1'b0, 8'd3, 1'b1);
        menu_btn = 1'b0;
        cyc(3);
        #2;
        rst = 1'b0;
        push_exp("t5_async_reset", 1'b1, 1'b0, 8'd0, 1'b0);
        #1;
        pop_cmp();
        #1;
        rst        = 1'b1;
        mode_state = 3'd0;
        chk(1, "t5_after_reset", 1'b1, 1'b0, 8'd0, 1'b0);

        // 6: menu held high across entry is not an edge
        menu_btn = 1'b1;
        cyc(2);
        mode_state = 3'd3;
        chk(1,  "t6_load",     1'b1, 1'b0, 8'd3, 1'b1);
        chk(5,  "t6_held",     1'b1, 1'b0, 8'd3, 1'b1);
        chk(24, "t6_last_sec", 1'b1, 1'b0, 8'd1, 1'b1);
        chk(1,  "t6_expire",   1'b0, 1'b1, 8'd0, 1'b0);
        menu_btn   = 1'b0;
        mode_state = 3'd0;
        chk(1,  "t6_used",     1'b0, 1'b0, 8'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hurricane_ctrl.md
# hurricane_ctrl

Hurricane (mode 3) supervisor sitting beside `mode_fsm`: it consumes `mode_state` and `menu_btn`, and produces `hurricane_mode_enabled` and `return_state`, which `mode_fsm` uses to enter and leave mode 3. It enforces one hurricane run per power-on and runs the 60 s countdown. On expiry it tells `mode_fsm` whether to drop to mode 2 (no menu press) or to standby (menu pressed during the run). It also exports the remaining seconds for the display path.

## Interface
- `CLK_FREQ`, 100_000_000, clock cycles per second
- `HURRICANE_SEC`, 60, run length in seconds, 1..255

- `clk`  in  1  system clock
- `rst`  in  1  reset; asynchronous assert, active-low
- `machine_state`  in  1  1 = machine powered on
- `mode_state`  in  3  current mode from `mode_fsm` (3'b011 = hurricane)
- `menu_btn`  in  1  debounced menu button level
- `hurricane_mode_enabled`  out  1  1 = entry to mode 3 permitted, or run still in progress
- `return_state`  out  1  valid while `hurricane_mode_enabled`=0 in EXIT: 1 = go to mode 2, 0 = go to standby
- `remaining_sec`  out  8  seconds left in the current run, 0 when not running
- `countdown_active`  out  1  1 in RUN or RUN_MENU

## Operation
- Reset values: `hurricane_mode_enabled`=1, `return_state`=0, `remaining_sec`=0, `countdown_active`=0, state ARMED, tick counter 0, menu edge register 0.
- States: ARMED, RUN, RUN_MENU, EXIT, USED.
- ARMED:
  - `enabled`=1.
  - `mode_state`==3'b011 → RUN; load `remaining_sec`=HURRICANE_SEC; clear tick counter.
- RUN:
  - `enabled`=1.
  - Rising edge of `menu_btn` → RUN_MENU; reload `remaining_sec`=HURRICANE_SEC; clear tick counter.
  - Countdown reaching 0 → EXIT with `return_state`=1.
- RUN_MENU:
  - Further menu edges are ignored.
  - Countdown reaching 0 → EXIT with `return_state`=0.
- EXIT:
  - `enabled`=0; `return_state` is held.
  - `mode_state`≠3'b011 → USED.
- USED:
  - `enabled`=0, `return_state`=0.
  - Mode 3 cannot be re-entered until power cycle.
- `mode_state` leaves 3'b011 during RUN or RUN_MENU while powered → USED; counters cleared.
- `machine_state`=0 in any state → ARMED next cycle, outputs at their reset values. This takes priority over every other transition.
- Menu edge and expiry in the same cycle: expiry wins; `return_state` follows the state held before that cycle.
- Menu edge detection uses a registered `menu_btn_prev`. A `menu_btn` that is already high on entry to RUN is not an edge.

## Timing
- Tick counter runs 0..CLK_FREQ-1 in RUN and RUN_MENU. When it wraps, `remaining_sec` decrements, saturating at 0.
- Entry latency: 1 cycle. `remaining_sec`=HURRICANE_SEC appears in the cycle after `mode_state` first reads 3'b011.
- Exit: `enabled` falls exactly HURRICANE_SEC×CLK_FREQ cycles after the load cycle (or after the reload cycle in RUN_MENU). `remaining_sec` reaches 0 in the same cycle.
- `return_state` is valid in the same cycle `enabled` falls, and stays stable until `mode_state` leaves 3'b011. `mode_fsm` samples it one cycle later.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `smoker_pkg`:
  - mode encodings: MODE_STANDBY=3'b000, MODE_1=3'b001, MODE_2=3'b010, MODE_3=3'b011, MODE_CLEAN=3'b100, MODE_SHOW_ANN=3'b101, MODE_SHOW_GEST=3'b110, MODE_SHOW_CUM=3'b111
  - default CLK_FREQ
- Hurricane state encoding stays local to the block.
- One sub-module, `sec_tick_gen`:
  - parameter CLK_FREQ; inputs `clk`, `rst`, `clear`, `run`; output `tick`, a one-cycle pulse at wrap
  - counter width $clog2(CLK_FREQ)
  - shared with the self-clean timer

## Test plan
Simulation parameters: CLK_FREQ=10, HURRICANE_SEC=3.
1. Reset, power on, `mode_state`=3 at cycle 5, no menu → `remaining_sec` 3→2→1→0 at 10-cycle spacing; `enabled` falls with `return_state`=1 at cycle 36; `mode_state`=2 → USED; a second `mode_state`=3 request sees `enabled`=0.
2. Enter mode 3, `menu_btn` rising edge 15 cycles in → `remaining_sec` reloads to 3; `enabled` falls 30 cycles after the reload with `return_state`=0.
3. Menu edge on the same cycle as final expiry in RUN → `return_state`=1; the state moves to EXIT, not RUN_MENU.
4. `machine_state`=0 mid-run, then 1 → ARMED, `enabled`=1, `remaining_sec`=0; re-entry to mode 3 runs a full 3 s.
5. `rst` pulsed low mid-RUN_MENU → outputs immediately at reset values (1,0,0,0) without waiting for a clock edge.
6. `menu_btn` held high before and through entry → no RUN_MENU transition; run ends with `return_state`=1.
